// File: rtl/bump_avoid_ctrl.sv
// bump_avoid_ctrl: bump-and-recover drive controller for the RSLK chassis.
// Button starts/stops; a bumper hit backs off, spins away, then resumes.
module bump_avoid_ctrl #(
  parameter int NUM_BUMP  = 6,
  parameter int DUTY_W    = 16,
  parameter int FWD_DUTY  = 4000,
  parameter int BACK_DUTY = 4000,
  parameter int TURN_DUTY = 3000,
  parameter int DEB_CYC   = 160000,
  parameter int BACK_CYC  = 8000000,
  parameter int TURN_CYC  = 6000000,
  parameter int MAX_HITS  = 0
) (
  input  logic                          WF_CLK,
  input  logic                          rst,
  input  logic                          WF_BUTTON,
  input  logic [NUM_BUMP-1:0]           bump,
  output logic                          motorL_en,
  output logic                          motorR_en,
  output logic                          motorL_dir,
  output logic                          motorR_dir,
  output logic                          motorL_drive,
  output logic                          motorR_drive,
  output logic [DUTY_W-1:0]             dutyL,
  output logic [DUTY_W-1:0]             dutyR,
  output logic                          ledFR,
  output logic                          ledFL,
  output logic                          ledBR,
  output logic                          ledBL,
  output logic [$clog2(MAX_HITS+2)-1:0] hit_count
);

  localparam int NIN    = NUM_BUMP + 1;
  localparam int HALF   = NUM_BUMP / 2;
  localparam int DEB_W  = $clog2(DEB_CYC + 1);
  localparam int PH_MAX = (BACK_CYC > TURN_CYC) ? BACK_CYC : TURN_CYC;
  localparam int PH_W   = $clog2(PH_MAX + 1);
  localparam int HIT_W  = $clog2(MAX_HITS + 2);

  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CYC);
  localparam logic [PH_W-1:0]   BACK_LAST = PH_W'(BACK_CYC - 1);
  localparam logic [PH_W-1:0]   TURN_LAST = PH_W'(TURN_CYC - 1);
  localparam logic [HIT_W-1:0]  HIT_LIM   = HIT_W'(MAX_HITS);
  localparam logic [DUTY_W-1:0] D_FWD     = DUTY_W'(FWD_DUTY);
  localparam logic [DUTY_W-1:0] D_BACK    = DUTY_W'(BACK_DUTY);
  localparam logic [DUTY_W-1:0] D_TURN    = DUTY_W'(TURN_DUTY);

  typedef enum logic [2:0] {
    INIT, IDLE, FWD, BACK, TURN, HALT
  } state_t;

  logic [NIN-1:0] syncA;
  logic [NIN-1:0] syncB;
  logic [NIN-1:0] deb;

  logic                btnDeb;
  logic                btnPrev;
  logic [NUM_BUMP-1:0] bumpDeb;
  logic                press;
  logic                hit;
  logic                leftHit;
  logic                rightHit;

  state_t           state;
  state_t           stateNext;
  logic [PH_W-1:0]  timer;
  logic [PH_W-1:0]  timerNext;
  logic [HIT_W-1:0] hitCnt;
  logic [HIT_W-1:0] hitNext;
  logic             turnRight;
  logic             turnNext;
  logic             haltNow;

  // Bit 0 carries the button, bits NIN-1:1 the bumpers.
  always_ff @(posedge WF_CLK) begin
    if (rst) begin
      syncA <= '1;
      syncB <= '1;
    end else begin
      syncA <= {bump, WF_BUTTON};
      syncB <= syncA;
    end
  end

  for (genvar i = 0; i < NIN; i++) begin : gDeb
    logic [DEB_W-1:0] cnt;
    logic             q;

    always_ff @(posedge WF_CLK) begin
      if (rst) begin
        cnt <= '0;
        q   <= 1'b1;
      end else if (syncB[i] == q) begin
        cnt <= '0;
      end else if (cnt == DEB_LAST) begin
        cnt <= '0;
        q   <= syncB[i];
      end else begin
        cnt <= cnt + 1'b1;
      end
    end

    assign deb[i] = q;
  end

  assign btnDeb   = deb[0];
  assign bumpDeb  = deb[NIN-1:1];
  assign press    = btnPrev & ~btnDeb;
  assign hit      = ~&bumpDeb;
  assign leftHit  = ~&bumpDeb[NUM_BUMP-1:HALF];
  assign rightHit = ~&bumpDeb[HALF-1:0];
  assign haltNow  = (MAX_HITS != 0) && (hitCnt == HIT_LIM);

  always_ff @(posedge WF_CLK) begin
    if (rst) begin
      state     <= INIT;
      timer     <= '0;
      hitCnt    <= '0;
      turnRight <= 1'b0;
      btnPrev   <= 1'b1;
    end else begin
      state     <= stateNext;
      timer     <= timerNext;
      hitCnt    <= hitNext;
      turnRight <= turnNext;
      btnPrev   <= btnDeb;
    end
  end

  always_comb begin
    stateNext = state;
    timerNext = timer;
    hitNext   = hitCnt;
    turnNext  = turnRight;
    unique case (state)
      INIT: stateNext = IDLE;
      IDLE: begin
        if (press) begin
          hitNext   = '0;
          stateNext = FWD;
        end
      end
      FWD: begin
        if (press) begin
          stateNext = IDLE;
        end else if (hit) begin
          turnNext  = leftHit & ~rightHit;
          timerNext = '0;
          stateNext = BACK;
          if (hitCnt != '1) hitNext = hitCnt + 1'b1;
        end
      end
      BACK: begin
        if (timer == BACK_LAST) begin
          timerNext = '0;
          stateNext = TURN;
        end else begin
          timerNext = timer + 1'b1;
        end
      end
      TURN: begin
        if (timer == TURN_LAST) begin
          timerNext = '0;
          stateNext = haltNow ? HALT : FWD;
        end else begin
          timerNext = timer + 1'b1;
        end
      end
      HALT: begin
        if (press) stateNext = IDLE;
      end
      default: stateNext = INIT;
    endcase
  end

  // Duty stays zero whenever the pwm drive enable is low.
  always_comb begin
    motorL_en    = 1'b0;
    motorR_en    = 1'b0;
    motorL_dir   = 1'b0;
    motorR_dir   = 1'b0;
    motorL_drive = 1'b0;
    motorR_drive = 1'b0;
    dutyL        = '0;
    dutyR        = '0;
    ledFR        = 1'b0;
    ledFL        = 1'b0;
    ledBR        = 1'b0;
    ledBL        = 1'b0;
    unique case (state)
      INIT: ;
      IDLE: begin
        motorL_en = 1'b1;
        motorR_en = 1'b1;
        ledBR     = 1'b1;
        ledBL     = 1'b1;
      end
      FWD: begin
        motorL_en    = 1'b1;
        motorR_en    = 1'b1;
        motorL_drive = 1'b1;
        motorR_drive = 1'b1;
        dutyL        = D_FWD;
        dutyR        = D_FWD;
        ledFR        = 1'b1;
        ledFL        = 1'b1;
      end
      BACK: begin
        motorL_en    = 1'b1;
        motorR_en    = 1'b1;
        motorL_dir   = 1'b1;
        motorR_dir   = 1'b1;
        motorL_drive = 1'b1;
        motorR_drive = 1'b1;
        dutyL        = D_BACK;
        dutyR        = D_BACK;
        ledBR        = 1'b1;
        ledBL        = 1'b1;
      end
      TURN: begin
        motorL_en    = 1'b1;
        motorR_en    = 1'b1;
        motorL_drive = 1'b1;
        motorR_drive = 1'b1;
        dutyL        = D_TURN;
        dutyR        = D_TURN;
        if (turnRight) begin
          motorR_dir = 1'b1;
          ledFR      = 1'b1;
        end else begin
          motorL_dir = 1'b1;
          ledFL      = 1'b1;
        end
      end
      HALT: begin
        motorL_en = 1'b1;
        motorR_en = 1'b1;
        ledFR     = 1'b1;
        ledFL     = 1'b1;
        ledBR     = 1'b1;
        ledBL     = 1'b1;
      end
      default: ;
    endcase
  end

  assign hit_count = hitCnt;

endmodule
